pixel_write_ctrl: RTL and testbench



---
 rtl/pixel_write_ctrl_if.sv | 22 ++
 rtl/pixel_write_ctrl.sv | 100 ++++++++++
 tb/tb_pixel_write_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_write_ctrl_if.sv
// rtl/pixel_write_ctrl_if.sv - renderer query and framebuffer write bus for pixel_write_ctrl
interface pixel_write_ctrl_if #(
  parameter int COLOR_W = 8,
  parameter int ADDR_W  = 20
) ();
  logic [9:0]         RenderX;
  logic [9:0]         RenderY;
  logic [COLOR_W-1:0] render_color;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               fb_we;

  modport master (
    output RenderX, RenderY, fb_addr, fb_data, fb_we,
    input  render_color
  );

  modport slave (
    input  RenderX, RenderY, fb_addr, fb_data, fb_we,
    output render_color
  );
endinterface

// File: rtl/pixel_write_ctrl.sv
// rtl/pixel_write_ctrl.sv - three-stage coordinate-to-framebuffer writer with double-buffer swap
module pixel_write_ctrl #(
  parameter int H_TOTAL = 640,
  parameter int V_TOTAL = 480,
  parameter int COLOR_W = 8,
  parameter int ADDR_W  = 20
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               enable,
  input  logic [9:0]         WriteX,
  input  logic [9:0]         WriteY,
  input  logic               swap_req,
  output logic               disp_buf,
  output logic               frame_done,
  output logic               swap_ack,
  pixel_write_ctrl_if.master bus
);
  localparam int OFF_W = ADDR_W - 1;
  localparam logic [9:0] X_END  = 10'(H_TOTAL);
  localparam logic [9:0] Y_END  = 10'(V_TOTAL);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, PENDING, SWAP} swap_state_t;

  swap_state_t       state, state_next;
  logic              disp_next;
  logic              accept;
  logic [OFF_W-1:0]  x_ext, y_ext, offset_in;
  logic              v1, v2, last1, last2;
  logic [ADDR_W-1:0] addr1, addr2;

  assign accept    = enable && (WriteX < X_END) && (WriteY < Y_END);
  assign x_ext     = OFF_W'(WriteX);
  assign y_ext     = OFF_W'(WriteY);
  assign offset_in = (y_ext << 9) + (y_ext << 7) + x_ext;
  assign swap_ack  = (state == SWAP);

  always_comb begin
    state_next = state;
    disp_next  = disp_buf;
    case (state)
      IDLE:    if (swap_req) state_next = PENDING;
      PENDING: begin
        if (frame_done) begin
          state_next = SWAP;
          disp_next  = ~disp_buf;
        end
      end
      SWAP:    state_next = swap_req ? PENDING : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= IDLE;
      disp_buf <= 1'b0;
    end else begin
      state    <= state_next;
      disp_buf <= disp_next;
    end
  end

  // bsel follows the post-edge disp_buf so pixels captured on the swap edge land in the new back buffer
  always_ff @(posedge clk) begin
    if (Reset) begin
      bus.RenderX  <= '0;
      bus.RenderY  <= '0;
      v1           <= 1'b0;
      last1        <= 1'b0;
      addr1        <= '0;
      v2           <= 1'b0;
      last2        <= 1'b0;
      addr2        <= '0;
      bus.fb_we    <= 1'b0;
      bus.fb_addr  <= '0;
      bus.fb_data  <= '0;
      frame_done   <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        bus.RenderX <= WriteX;
        bus.RenderY <= WriteY;
        addr1       <= {~disp_next, offset_in};
        last1       <= (WriteX == X_LAST) && (WriteY == Y_LAST);
      end
      v2         <= v1;
      addr2      <= addr1;
      last2      <= v1 && last1;
      bus.fb_we  <= v2;
      frame_done <= v2 && last2;
      if (v2) begin
        bus.fb_addr <= addr2;
        bus.fb_data <= bus.render_color;
      end
    end
  end
endmodule

// File: tb/tb_pixel_write_ctrl.sv
// tb/tb_pixel_write_ctrl.sv - self-checking bench for pixel_write_ctrl
module tb_pixel_write_ctrl;
  localparam int N = 4096;

  logic       clk = 1'b0;
  logic       Reset, enable, swap_req;
  logic [9:0] WriteX, WriteY;
  logic       disp_buf, frame_done, swap_ack;

  always #5 clk = ~clk;

  pixel_write_ctrl_if #(.COLOR_W(8), .ADDR_W(20)) bus ();

  pixel_write_ctrl #(.H_TOTAL(640), .V_TOTAL(480), .COLOR_W(8), .ADDR_W(20)) dut (
    .clk(clk), .Reset(Reset), .enable(enable), .WriteX(WriteX), .WriteY(WriteY),
    .swap_req(swap_req), .disp_buf(disp_buf), .frame_done(frame_done),
    .swap_ack(swap_ack), .bus(bus)
  );

  typedef struct {
    bit        en;
    int        x;
    int        y;
    bit [7:0]  color;
    bit        exp_we;
    bit        exp_fd;
    bit [19:0] exp_addr;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  int npass = 0;
  int ntotal = 0;
  int cyc;

  // stimulus history and expected outputs, indexed by cycle
  bit        en_h[N], sreq_h[N], rst_h[N];
  bit [9:0]  x_h[N], y_h[N];
  bit [7:0]  col_h[N];
  bit [9:0]  e_rx[N], e_ry[N];
  bit [19:0] e_addr[N], paddr[N];
  bit [7:0]  e_data[N];
  bit        e_we[N], e_disp[N], e_fd[N], e_ack[N], pend[N], pv[N], plast[N];

  int        acks, fd_cyc, ack_cyc;
  bit [19:0] wq[$];

  task automatic check(string name, longint unsigned got, longint unsigned exp);
    ntotal++;
    if (got == exp) npass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
  endtask

  // Reference: screen offset y*640+x, write appears 3 cycles after acceptance, colour from
  // the cycle before the write, swap one cycle after a frame_done seen while a request waits.
  task automatic model();
    int c = cyc;
    int x, y;
    bit acc, wr;
    if (rst_h[c-1]) begin
      e_rx[c] = 0; e_ry[c] = 0; e_addr[c] = 0; e_data[c] = 0; e_we[c] = 0;
      e_disp[c] = 0; e_fd[c] = 0; e_ack[c] = 0; pend[c] = 0; pv[c] = 0;
    end else begin
      x = int'(x_h[c-1]);
      y = int'(y_h[c-1]);
      acc = en_h[c-1] && x < 640 && y < 480;
      e_rx[c]   = acc ? x_h[c-1] : e_rx[c-1];
      e_ry[c]   = acc ? y_h[c-1] : e_ry[c-1];
      e_ack[c]  = pend[c-1] && e_fd[c-1];
      e_disp[c] = e_disp[c-1] ^ e_ack[c];
      pend[c]   = pend[c-1] ? !e_fd[c-1] : sreq_h[c-1];
      pv[c]     = acc;
      paddr[c]  = {~e_disp[c], 19'(y * 640 + x)};
      plast[c]  = (x == 639) && (y == 479);
      wr        = pv[c-2] && !rst_h[c-2];
      e_we[c]   = wr;
      e_fd[c]   = wr && plast[c-2];
      e_addr[c] = wr ? paddr[c-2] : e_addr[c-1];
      e_data[c] = wr ? col_h[c-1] : e_data[c-1];
    end
  endtask

  task automatic tick();
    en_h[cyc] = enable; x_h[cyc] = WriteX; y_h[cyc] = WriteY;
    sreq_h[cyc] = swap_req; rst_h[cyc] = Reset; col_h[cyc] = bus.render_color;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= N) begin
      $display("FAIL cycle_budget: got %0d cycles expected below %0d", cyc, N);
      $fatal(1);
    end
    model();
    check("model", 64'({bus.RenderX, bus.RenderY, bus.fb_addr, bus.fb_data, bus.fb_we,
                        disp_buf, frame_done, swap_ack}),
                   64'({e_rx[cyc], e_ry[cyc], e_addr[cyc], e_data[cyc], e_we[cyc],
                        e_disp[cyc], e_fd[cyc], e_ack[cyc]}));
    if (bus.fb_we) wq.push_back(bus.fb_addr);
    if (frame_done) fd_cyc = cyc;
    if (swap_ack) begin acks++; ack_cyc = cyc; end
  endtask

  task automatic set_in(bit en, int x, int y, bit sreq);
    enable = en; WriteX = 10'(x); WriteY = 10'(y); swap_req = sreq;
    bus.render_color = 8'($urandom);
  endtask

  task automatic step(bit en, int x, int y, bit sreq);
    set_in(en, x, y, sreq);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ones, sixes, mode, x, y;
    vecs[0] = '{1, 0,    0,    8'h11, 1, 0, 20'h80000};
    vecs[1] = '{1, 100,  2,    8'h22, 1, 0, 20'h80564};
    vecs[2] = '{1, 640,  5,    8'h33, 0, 0, 20'h0};
    vecs[3] = '{1, 3,    480,  8'h44, 0, 0, 20'h0};
    vecs[4] = '{0, 7,    7,    8'h55, 0, 0, 20'h0};
    vecs[5] = '{1, 639,  479,  8'hA5, 1, 1, 20'hCAFFF};
    vecs[6] = '{1, 0,    1,    8'h3C, 1, 0, 20'h80280};
    vecs[7] = '{1, 1023, 1023, 8'h66, 0, 0, 20'h0};
    vecs[8] = '{1, 5,    0,    8'h00, 1, 0, 20'h80005};

    cyc = 2;
    rst_h[0] = 1; rst_h[1] = 1;
    acks = 0; fd_cyc = -1; ack_cyc = -1;
    Reset = 1;
    set_in(1, 0, 0, 0);
    repeat (2) begin
      tick();
      check("reset_outputs", 64'({bus.RenderX, bus.RenderY, bus.fb_addr, bus.fb_data,
                                  bus.fb_we, disp_buf, frame_done, swap_ack}), 0);
    end
    Reset = 0;

    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) set_in(vecs[i].en, vecs[i].x, vecs[i].y, 0);
      else set_in(0, 0, 0, 0);
      if (i >= 2) bus.render_color = vecs[i-2].color;
      tick();
      if (i < 2) check("first_we_early", 64'(bus.fb_we), 0);
      else begin
        check("tbl_we", 64'(bus.fb_we), 64'(vecs[i-2].exp_we));
        check("tbl_frame_done", 64'(frame_done), 64'(vecs[i-2].exp_fd));
        if (vecs[i-2].exp_we) begin
          check("tbl_addr", 64'(bus.fb_addr), 64'(vecs[i-2].exp_addr));
          check("tbl_data", 64'(bus.fb_data), 64'(vecs[i-2].color));
        end
      end
    end

    acks = 0; fd_cyc = -1; ack_cyc = -1; wq.delete();
    step(1, 10, 479, 1);
    step(1, 11, 479, 1);
    for (int i = 637; i < 640; i++) step(1, i, 479, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    check("swap_count", 64'(acks), 1);
    check("swap_ack_delay", 64'(ack_cyc), 64'(fd_cyc + 1));
    check("disp_after_swap", 64'(disp_buf), 1);
    check("new_frame_writes", 64'(wq.size()), 7);
    check("new_frame_origin", 64'(wq[wq.size()-2]), 20'h00000);
    check("new_frame_next", 64'(wq[wq.size()-1]), 20'h00001);

    acks = 0;
    step(1, 639, 479, 0);
    repeat (6) step(0, 0, 0, 0);
    check("no_second_swap", 64'(acks), 0);
    check("disp_held", 64'(disp_buf), 1);

    wq.delete();
    for (int i = 0; i < 20; i++) step(!(i >= 7 && i < 12), 200 + i, 50, 0);
    repeat (4) step(0, 0, 0, 0);
    ones = 0; sixes = 0;
    for (int k = 1; k < wq.size(); k++) begin
      if (wq[k] - wq[k-1] == 20'd1) ones++;
      if (wq[k] - wq[k-1] == 20'd6) sixes++;
    end
    check("bubble_writes", 64'(wq.size()), 15);
    check("bubble_consecutive", 64'(ones), 13);
    check("bubble_gap", 64'(sixes), 1);
    check("bubble_first_addr", 64'(wq[0]), 32200);

    for (int i = 0; i < 4; i++) step(1, 300 + i, 10, 0);
    check("we_before_reset", 64'(bus.fb_we), 1);
    Reset = 1;
    step(1, 304, 10, 0);
    check("we_after_reset", 64'(bus.fb_we), 0);
    check("disp_after_reset", 64'(disp_buf), 0);
    Reset = 0;
    wq.delete();
    repeat (6) step(0, 0, 0, 0);
    check("no_stale_write", 64'(wq.size()), 0);

    for (int i = 0; i < 2000; i++) begin
      mode = $urandom_range(0, 15);
      if (mode == 0) begin x = 639; y = 479; end
      else if (mode == 1) begin x = $urandom_range(630, 650); y = $urandom_range(470, 490); end
      else begin x = $urandom_range(0, 700); y = $urandom_range(0, 520); end
      Reset = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 9) != 0, x, y, $urandom_range(0, 19) == 0);
    end
    Reset = 0;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
